mem_port_arbiter: RTL and testbench

Two-requester arbiter and sequencer for the single unified memory port of the multi-cycle CPU. It shares the memory between the CPU controller's fetch/load/store accesses (requester 0) and the program loader/debug port (requester 1). It serializes their accesses and drives the memory read/write strobes, address and write data. It returns read data and a one-cycle acknowledge to the winning requester.

---
 rtl/mem_port_arbiter_pkg.sv | 18 +
 rtl/mem_port_arbiter_arb_pick2.sv | 30 +++
 rtl/mem_port_arbiter.sv | 146 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the unified memory port arbiter: FSM state
// encoding, requester indices and the legal read-latency window.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_LDR = 1'b1;

  localparam int RD_LAT_MIN = 1;
  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/mem_port_arbiter_arb_pick2.sv
// Combinational two-way picker. Build option MEM_ARB_RR_EN selects
// round-robin on a tie (the requester that was not granted last wins);
// otherwise the CPU requester always has priority.
module arb_pick2
  import mem_port_arbiter_pkg::*;
(
  input  logic req0_i,
  input  logic req1_i,
  input  logic last_owner_i,
  output logic gnt_idx_o,
  output logic gnt_vld_o
);

  // Choose the winner among the currently asserted requests.
  always_comb begin
    gnt_vld_o = req0_i | req1_i;
    gnt_idx_o = req0_i ? REQ_CPU : REQ_LDR;
`ifdef MEM_ARB_RR_EN
    if (req0_i && req1_i) begin
      gnt_idx_o = ~last_owner_i;
    end
`else
    // Fixed priority ignores history; owner is still tracked by the top.
    if (last_owner_i && 1'b0) begin
      gnt_idx_o = REQ_LDR;
    end
`endif
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter/sequencer for the CPU's single memory port.
// Requester 0 is the CPU controller, requester 1 the loader/debug port.
// Optional build macro: MEM_ARB_RR_EN (round-robin tie breaking).
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int RD_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_req0,
  input  logic          i_we0,
  input  logic [AW-1:0] i_addr0,
  input  logic [DW-1:0] i_wdata0,
  output logic          o_ack0,
  output logic [DW-1:0] o_rdata0,
  input  logic          i_req1,
  input  logic          i_we1,
  input  logic [AW-1:0] i_addr1,
  input  logic [DW-1:0] i_wdata1,
  output logic          o_ack1,
  output logic [DW-1:0] o_rdata1,
  output logic          o_mem_re,
  output logic          o_mem_we,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_wdata,
  input  logic [DW-1:0] i_mem_rdata,
  output logic          o_busy,
  output logic          o_owner
);

  if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $error("mem_port_arbiter: RD_LAT must be within 1..4");
  end

  localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic [DW-1:0] rdata0_q, rdata1_q;
  logic          gnt_idx, gnt_vld;
  logic          capture, sample;

  arb_pick2 u_pick (
    .req0_i       (i_req0),
    .req1_i       (i_req1),
    .last_owner_i (owner_q),
    .gnt_idx_o    (gnt_idx),
    .gnt_vld_o    (gnt_vld)
  );

  // Next-state logic: grant in IDLE, one strobe cycle, optional wait, ack.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    capture = 1'b0;
    sample  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (gnt_vld) begin
          owner_d = gnt_idx;
          capture = 1'b1;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (we_q) begin
          state_d = ST_DONE;
        end else if (RD_LAT == 1) begin
          sample  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d   = LAT_LOAD;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A count of 0 cannot occur; treat it like 1 so the FSM never sticks.
        if (cnt_q <= 3'd1) begin
          sample  = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control state register; owner resets to LDR so CPU wins the first tie.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      owner_q <= REQ_LDR;
      cnt_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

  // Freeze the winner's command at grant; later input changes are ignored.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (capture) begin
      we_q    <= (gnt_idx == REQ_LDR) ? i_we1    : i_we0;
      addr_q  <= (gnt_idx == REQ_LDR) ? i_addr1  : i_addr0;
      wdata_q <= (gnt_idx == REQ_LDR) ? i_wdata1 : i_wdata0;
    end
  end

  // Read-return registers hold their value between acknowledges.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (sample) begin
      if (owner_q == REQ_LDR) rdata1_q <= i_mem_rdata;
      else                    rdata0_q <= i_mem_rdata;
    end
  end

  assign o_mem_re    = (state_q == ST_ISSUE) && !we_q;
  assign o_mem_we    = (state_q == ST_ISSUE) &&  we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_ack0      = (state_q == ST_DONE) && (owner_q == REQ_CPU);
  assign o_ack1      = (state_q == ST_DONE) && (owner_q == REQ_LDR);
  assign o_rdata0    = rdata0_q;
  assign o_rdata1    = rdata1_q;
  assign o_busy      = (state_q != ST_IDLE);
  assign o_owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a latency-accurate memory
// device and a transaction-level reference model of arbitration and data.
module tb_mem_port_arbiter;

  localparam int RD_LAT = 3;

  logic        clk;
  logic        rst;
  logic        req   [2];
  logic        we    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1;
  logic        mem_re, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        busy, owner;

  mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(RD_LAT)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req0      (req[0]),
    .i_we0       (we[0]),
    .i_addr0     (addr[0]),
    .i_wdata0    (wdata[0]),
    .o_ack0      (ack0),
    .o_rdata0    (rdata0),
    .i_req1      (req[1]),
    .i_we1       (we[1]),
    .i_addr1     (addr[1]),
    .i_wdata1    (wdata[1]),
    .o_ack1      (ack1),
    .o_rdata1    (rdata1),
    .o_mem_re    (mem_re),
    .o_mem_we    (mem_we),
    .o_mem_addr  (mem_addr),
    .o_mem_wdata (mem_wdata),
    .i_mem_rdata (mem_rdata),
    .o_busy      (busy),
    .o_owner     (owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int idx);
    return 32'hC0DE_0000 | 32'(idx);
  endfunction

  // Memory device: data is only valid in the cycle it should be sampled.
  int          cyc = 0;
  int          rd_due = -10;
  bit          rd_pend;
  int          rd_idx = 0;
  logic [31:0] dmem   [64];
  bit          dmem_v [64];

  function automatic logic [31:0] dev_rd(input int idx);
    return dmem_v[idx] ? dmem[idx] : init_val(idx);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mem_we) begin
      dmem[mem_addr[7:2]]   <= mem_wdata;
      dmem_v[mem_addr[7:2]] <= 1'b1;
    end
    if (mem_re) begin
      rd_idx  <= int'(mem_addr[7:2]);
      rd_due  <= cyc + RD_LAT - 1;
      rd_pend <= 1'b1;
    end
  end

  always_comb begin
    mem_rdata = ~dev_rd(rd_idx);
    if (rd_pend && cyc == rd_due) mem_rdata = dev_rd(rd_idx);
  end

  // Reference model state
  logic [31:0] rmem [64];
  bit          model_last;

  function automatic bit ref_winner(input bit r0, input bit r1, input bit last);
    if (r0 && !r1) return 1'b0;
    if (r1 && !r0) return 1'b1;
`ifdef MEM_ARB_RR_EN
    return !last;
`else
    return (last && 1'b0);
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One lone transaction with cycle-exact expectations.
  task automatic run_txn(input int who, input bit w, input logic [31:0] a,
                         input logic [31:0] d, input bit wiggle);
    logic [31:0] exp_rd;
    int lat;
    req[who] = 1'b1; we[who] = w; addr[who] = a; wdata[who] = d;
    step();
    check("strb_we", mem_we, w);
    check("strb_re", mem_re, !w);
    check("mem_addr", mem_addr, a);
    if (w) check("mem_wdata", mem_wdata, d);
    check("owner", owner, who[0]);
    check("busy", busy, 1'b1);
    model_last = who[0];
    exp_rd = rmem[a[7:2]];
    if (w) rmem[a[7:2]] = d;
    if (wiggle) begin
      addr[who] = a ^ 32'h80; wdata[who] = ~d; req[who] = 1'b0;
    end
    lat = w ? 1 : RD_LAT;
    for (int k = 1; k < lat; k++) begin
      step();
      check("early_ack", {ack1, ack0}, 2'b00);
      check("wait_strb", {mem_re, mem_we}, 2'b00);
      check("frozen_addr", mem_addr, a);
    end
    step();
    check("ack", {ack1, ack0}, (who == 1) ? 2'b10 : 2'b01);
    check("done_addr", mem_addr, a);
    if (!w) check("rdata", (who == 1) ? rdata1 : rdata0, exp_rd);
    req[who] = 1'b0;
    step();
    check("ack_gone", {ack1, ack0}, 2'b00);
    check("idle", busy, 1'b0);
    if (!w) check("rdata_hold", (who == 1) ? rdata1 : rdata0, exp_rd);
  endtask

  // Random-phase scoreboard state
  bit          p_idle;
  bit          p_req [2];
  bit          p_we  [2];
  logic [31:0] p_addr[2];
  logic [31:0] p_wd  [2];
  int          exp_ack_at;
  int          exp_who;
  bit          exp_isrd;
  logic [31:0] exp_rd;
  int          n_grant, n_ack, ngot;
  bit          wsel;

  initial begin
    for (int i = 0; i < 64; i++) begin
      rmem[i] = init_val(i);
      dmem[i] = 32'h0;
    end
    rst = 1'b0;
    for (int r = 0; r < 2; r++) begin
      req[r] = 1'b0; we[r] = 1'b0; addr[r] = 32'h0; wdata[r] = 32'h0;
    end
    model_last = 1'b1;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_strb", {mem_re, mem_we}, 2'b00);
    check("rst_ack", {ack1, ack0}, 2'b00);
    check("rst_busy", busy, 1'b0);
    check("rst_owner", owner, 1'b1);
    check("rst_addr", mem_addr, 32'h0);
    check("rst_wdata", mem_wdata, 32'h0);
    check("rst_rdata", {rdata1, rdata0}, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    step();

    // Lone CPU write, then loader write+read of 0x1234 at 0x20
    run_txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0);
    run_txn(1, 1'b1, 32'h20, 32'h0000_1234, 1'b0);
    run_txn(1, 1'b0, 32'h20, 32'h0, 1'b0);
    run_txn(0, 1'b0, 32'h10, 32'h0, 1'b0);

    // Both requesters held high: observe the grant order
    req[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h50;
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h54;
    ngot = 0;
    for (int k = 0; k < 60 && ngot < 4; k++) begin
      step();
      if (mem_re) begin
        wsel = ref_winner(1'b1, 1'b1, model_last);
        check("t3_grant", owner, wsel);
        check("t3_addr", mem_addr, wsel ? 32'h54 : 32'h50);
        model_last = wsel;
        ngot++;
      end
    end
    check("t3_count", ngot, 4);
    req[0] = 1'b0; req[1] = 1'b0;
    for (int k = 0; k < 20 && busy; k++) step();
    check("t3_drain", busy, 1'b0);

    // CPU read that drops req and changes address right after grant
    run_txn(0, 1'b0, 32'h30, 32'h0, 1'b1);
    step();
    check("no_regrant", {mem_re, mem_we}, 2'b00);

    // Reset while the loader read is waiting on memory
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h40;
    step();
    step();
    req[1] = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_strb", {mem_re, mem_we}, 2'b00);
    check("mid_rst_ack", {ack1, ack0}, 2'b00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_owner", owner, 1'b1);
    check("mid_rst_rdata1", rdata1, 32'h0);
    step();
    step();
    check("rst_hold_ack", {ack1, ack0}, 2'b00);
    #3 rst = 1'b0;
    model_last = 1'b1;
    step();
    run_txn(1, 1'b0, 32'h44, 32'h0, 1'b0);

    // Random mix on both ports against the reference model
    p_idle = 1'b1;
    for (int r = 0; r < 2; r++) begin
      p_req[r] = 1'b0; p_we[r] = 1'b0; p_addr[r] = 32'h0; p_wd[r] = 32'h0;
    end
    exp_ack_at = -1; exp_who = 0; exp_isrd = 1'b0; exp_rd = 32'h0;
    n_grant = 0; n_ack = 0;
    for (int k = 0; k < 900; k++) begin
      step();
      check("excl", mem_re & mem_we, 1'b0);
      check("grant", mem_re | mem_we, p_idle && (p_req[0] || p_req[1]));
      if (p_idle && (p_req[0] || p_req[1]) && (mem_re || mem_we)) begin
        wsel = ref_winner(p_req[0], p_req[1], model_last);
        check("r_owner", owner, wsel);
        check("r_we", mem_we, p_we[wsel]);
        check("r_addr", mem_addr, p_addr[wsel]);
        if (p_we[wsel]) begin
          check("r_wdata", mem_wdata, p_wd[wsel]);
          rmem[p_addr[wsel][7:2]] = p_wd[wsel];
        end else begin
          exp_rd = rmem[p_addr[wsel][7:2]];
        end
        model_last = wsel;
        exp_ack_at = k + (p_we[wsel] ? 1 : RD_LAT);
        exp_who = int'(wsel);
        exp_isrd = !p_we[wsel];
        n_grant++;
      end
      check("r_ack", {ack1, ack0}, (k == exp_ack_at) ? ((exp_who == 1) ? 2'b10 : 2'b01) : 2'b00);
      if (k == exp_ack_at && exp_isrd)
        check("r_rdata", (exp_who == 1) ? rdata1 : rdata0, exp_rd);
      if (ack0 || ack1) n_ack++;
      for (int r = 0; r < 2; r++) begin
        if (req[r] && ((r == 0) ? ack0 : ack1)) req[r] = 1'b0;
        if (!req[r] && k < 800 && $urandom_range(0, 3) == 0) begin
          req[r]   = 1'b1;
          we[r]    = $urandom_range(0, 1) == 1;
          addr[r]  = 32'($urandom_range(0, 15)) << 2;
          wdata[r] = $urandom;
        end
      end
      p_idle = !busy;
      for (int r = 0; r < 2; r++) begin
        p_req[r] = req[r]; p_we[r] = we[r]; p_addr[r] = addr[r]; p_wd[r] = wdata[r];
      end
    end
    check("drain_done", {req[0], req[1], busy}, 3'b000);
    check("grant_vs_ack", n_ack, n_grant);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
